dmem_responder: RTL and testbench

- Handshaked data-memory target: the responder end of the core's data-memory interface (addr / wdata / we / size / sign / rdata).
- Accepts one load or store request at a time.
- Models a fixed access latency and performs byte, half and word lane handling with sign or zero extension.
- Returns one response per request and flags misaligned or out-of-range accesses.
- Replaces the combinational data memory wherever the core or a testbench needs multi-cycle memory timing.

---
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: one load/store at a time, fixed latency,
// byte/half/word lane handling with sign/zero extension and fault flagging.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    // Handshake rules: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with resp_valid && resp_ready.
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic                    lat_sign;
    logic [31:0]             lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [1:0]              lat_size;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    commit;
    logic                    err;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wlanes;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [DATA_WIDTH-1:0]   load_data;

    assign req_ready = rst_n && (state == IDLE);
    assign commit    = (state == WAIT) && (cnt == 4'd0);
    assign idx       = lat_addr[ADDR_WIDTH+1:2];
    assign rd_word   = mem[idx];
    assign rd_shift  = rd_word >> {lat_addr[1:0], 3'b000};

    always_comb begin
        err       = 1'b0;
        be        = 4'b0000;
        wlanes    = lat_wdata;
        load_data = rd_word;
        case (lat_size)
            2'b00: begin
                be        = 4'b0001 << lat_addr[1:0];
                wlanes    = {4{lat_wdata[7:0]}};
                load_data = {{24{lat_sign & rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b01: begin
                err       = lat_addr[0];
                be        = lat_addr[1] ? 4'b1100 : 4'b0011;
                wlanes    = {2{lat_wdata[15:0]}};
                load_data = {{16{lat_sign & rd_shift[15]}}, rd_shift[15:0]};
            end
            2'b10: begin
                err = |lat_addr[1:0];
                be  = 4'b1111;
            end
            default: err = 1'b1;
        endcase
        if (|lat_addr[31:ADDR_WIDTH+2]) err = 1'b1;
    end

    // Array has no reset: contents survive rst_n, and only a commit edge writes it.
    always_ff @(posedge clk) begin
        if (commit && lat_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_sign   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_size   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_size  <= req_size;
                        lat_sign  <= req_sign;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || lat_we) ? '0 : load_data;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder, checked against a
// byte-addressed reference memory; two instances cover LATENCY 2 and 1.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        resp_ready;

    logic        rr0, vv0, er0, rr1, vv1, er1;
    logic [31:0] rd0, rd1;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0] ref_m0 [int unsigned];
    bit [7:0] ref_m1 [int unsigned];

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rr0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign), .resp_valid(vv0),
        .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign), .resp_valid(vv1),
        .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(er1)
    );

    assign req_ready  = sel ? rr1 : rr0;
    assign resp_valid = sel ? vv1 : vv0;
    assign resp_rdata = sel ? rd1 : rd0;
    assign resp_err   = sel ? er1 : er0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: byte-addressed memory, faults from the access rules
    function automatic bit [7:0] ref_rd(input bit s, input int unsigned a);
        if (s) return ref_m1.exists(a) ? ref_m1[a] : 8'h00;
        return ref_m0.exists(a) ? ref_m0[a] : 8'h00;
    endfunction

    function automatic void ref_access(input bit s, input bit we, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [1:0] sz,
                                       input bit sg, output logic [31:0] rd, output logic er);
        int unsigned n;
        logic [31:0] v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || (a % n != 0) || (a >= 32'd4096);
        rd = 32'h0;
        if (er) return;
        if (we) begin
            for (int unsigned i = 0; i < n; i++) begin
                if (s) ref_m1[a + i] = wd[8*i +: 8];
                else   ref_m0[a + i] = wd[8*i +: 8];
            end
        end else begin
            v = 32'h0;
            for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_rd(s, a + i)) << (8 * i));
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    // driver tasks
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sg);
        int n;
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_sign = sg;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_sign = 1'($urandom);
    endtask

    task automatic await_resp(input int lat, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 40);
        check("latency", 32'(n), 32'(lat));
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("resp_clear", {29'd0, resp_valid, resp_err, ~req_ready} | resp_rdata, 32'd0);
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit sg, output logic [31:0] rd);
        logic [31:0] erd;
        logic        eer;
        logic        er;
        ref_access(sel, we, a, wd, sz, sg, erd, eer);
        issue(we, a, wd, sz, sg);
        await_resp(sel ? 1 : 2, rd, er);
        check(we ? "st_rdata" : "ld_rdata", rd, erd);
        check(we ? "st_err" : "ld_err", {31'd0, er}, {31'd0, eer});
        release_resp();
    endtask

    // scoreboard of directed literal expectations
    logic [31:0] exp_q[$];

    task automatic expect_lit(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, obs, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    initial begin
        logic [31:0] rd, brd, erd;
        logic        ber, eer;
        logic [31:0] a;
        logic [1:0]  sz;
        int          off;

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = 2'b00; req_sign = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // word store / load
        txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd);
        txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd);
        exp_q.push_back(32'hDEADBEEF); expect_lit("word_load", rd);

        // byte and half lanes
        txn(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, rd);
        txn(1'b1, 32'h22, 32'hFFFFFFAA, 2'b00, 1'b0, rd);
        txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd);
        exp_q.push_back(32'h11AA3344); expect_lit("byte_merge", rd);
        txn(1'b0, 32'h22, 32'h0, 2'b00, 1'b1, rd);
        exp_q.push_back(32'hFFFFFFAA); expect_lit("lb_sign", rd);
        txn(1'b0, 32'h22, 32'h0, 2'b00, 1'b0, rd);
        exp_q.push_back(32'h000000AA); expect_lit("lb_zero", rd);
        txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, rd);
        exp_q.push_back(32'h000011AA); expect_lit("lh_sign", rd);

        // misalign and range faults
        txn(1'b0, 32'h21, 32'h0, 2'b01, 1'b0, rd);
        txn(1'b1, 32'h22, 32'hCAFEF00D, 2'b10, 1'b0, rd);
        txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd);
        exp_q.push_back(32'h11AA3344); expect_lit("misalign_nowrite", rd);
        txn(1'b0, 32'h20, 32'h0, 2'b11, 1'b0, rd);
        txn(1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, rd);
        txn(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, rd);

        // backpressure: response held, new request waits for the handshake
        ref_access(1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, brd, ber);
        issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        await_resp(2, rd, ber);
        check("bp_rdata", rd, brd);
        ref_access(1'b0, 1'b1, 32'h24, 32'h00000077, 2'b00, 1'b0, erd, eer);
        req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h00000077; req_size = 2'b00;
        req_sign = 1'b0; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_hold_rdata", resp_rdata, brd);
            check("bp_hold_err", {31'd0, resp_err}, 32'd0);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp_released", {31'd0, resp_valid}, 32'd0);
        check("bp_ready_after", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_accepted", {31'd0, req_ready}, 32'd0);
        await_resp(2, rd, ber);
        check("bp_st_err", {31'd0, ber}, {31'd0, eer});
        release_resp();
        txn(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, rd);

        // reset while a store is in WAIT
        txn(1'b1, 32'h30, 32'h0, 2'b10, 1'b0, rd);
        issue(1'b1, 32'h30, 32'h00000055, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        check("mid_rst_err", {31'd0, resp_err}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_ready2", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd);
        exp_q.push_back(32'h0); expect_lit("rst_discard", rd);

        // LATENCY = 1 random sweep
        sel = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            a = 32'($urandom_range(0, 1023)) * 4;
            txn(1'b1, a, $urandom, 2'b10, 1'b0, rd);
            sz  = 2'($urandom_range(0, 2));
            off = (sz == 2'd0) ? $urandom_range(0, 3) : (sz == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
            txn(1'b0, a + 32'(off), 32'h0, sz, 1'($urandom), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
